instr_decode_stage: RTL and testbench

//  RV32I decode stage, directly downstream of instruction fetch. Consumes the fetched

---
 rtl/instr_decode_stage_pkg.sv | 79 +++++++
 rtl/instr_decode_stage_reg_file.sv | 49 ++++
 rtl/instr_decode_stage.sv | 181 ++++++++++++++++++
 tb/tb_instr_decode_stage.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/instr_decode_stage_pkg.sv
// Shared definitions for the RV32I decode stage: opcode values, ALU control
// and result-source encodings, the decode->execute pipeline record and a
// helper that maps funct3/funct7[5] to an ALU operation.
package instr_decode_stage_pkg;

  localparam int unsigned XLEN_DEF     = 32;
  localparam int unsigned NUM_REGS_DEF = 32;

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OP_IMM = 7'b0010011,
    OPC_OP     = 7'b0110011
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_ADD_PC = 4'd10  // operand A is pc (AUIPC, JAL target)
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    RES_ALU     = 2'b00,
    RES_MEM     = 2'b01,
    RES_NEXT_PC = 2'b10,
    RES_IMM     = 2'b11
  } result_src_e;

  typedef struct packed {
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    alu_ctrl_e   alu_ctrl;
    logic        alu_src;
    result_src_e result_src;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        valid;
    logic        illegal;
  } dx_t;

  // alt is funct7[5]; SUB only exists on register-register OP, SRA/SRAI on both.
  function automatic alu_ctrl_e alu_op(input logic [2:0] f3, input logic alt,
                                       input logic is_op);
    case (f3)
      3'b000:  return (alt && is_op) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/instr_decode_stage_reg_file.sv
// 2-read / 1-write architectural register file.
//   clk, reset (sync, active-low: clears every register)
//   rs1_addr/rs2_addr -> rs1_data/rs2_data : combinational reads, x0 reads 0
//   wb_we, wb_rd, wb_data                   : posedge write, x0 never written
// Build option WB_BYPASS_EN: a read of the register being written this cycle
// returns wb_data (write-through); otherwise the pre-write value is returned.
module instr_decode_stage_reg_file
  import instr_decode_stage_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEF,
  parameter int unsigned NUM_REGS = NUM_REGS_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data
);

  logic [XLEN-1:0] regs_q [NUM_REGS];
  logic [XLEN-1:0] regs_d [NUM_REGS];
  logic            wr_en;

  assign wr_en = wb_we && (wb_rd != '0);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[wb_rd] = wb_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) regs_q <= '{default: '0};
    else        regs_q <= regs_d;
  end

  always_comb begin
    rs1_data = (rs1_addr == '0) ? '0 : regs_q[rs1_addr];
    rs2_data = (rs2_addr == '0) ? '0 : regs_q[rs2_addr];
`ifdef WB_BYPASS_EN
    if (wr_en && (wb_rd == rs1_addr)) rs1_data = wb_data;
    if (wr_en && (wb_rd == rs2_addr)) rs2_data = wb_data;
`endif
  end

endmodule

// File: rtl/instr_decode_stage.sv
// RV32I decode stage. Decodes the fetched instruction into execute-stage
// control, builds the sign-extended immediate, reads the register file and
// registers everything into the decode->execute pipeline register.
//   Inputs : clk, reset (sync, active-low), instr_decode, pc_decode,
//            next_pc_decode, valid, stall (hold), flush (bubble),
//            wb_we/wb_rd/wb_data (register-file writeback)
//   Outputs: *_exec operand values, immediate, register indices, funct3,
//            ALU/result-source/memory/branch/jump control, PCs,
//            valid_exec and illegal_exec
// Edge priority: !reset > flush > stall > load.
// Build option WB_BYPASS_EN: register-file write-through (see reg_file).
module instr_decode_stage
  import instr_decode_stage_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEF,
  parameter int unsigned NUM_REGS = NUM_REGS_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] instr_decode,
  input  logic [XLEN-1:0] pc_decode,
  input  logic [XLEN-1:0] next_pc_decode,
  input  logic            valid,
  input  logic            stall,
  input  logic            flush,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] rs1_data_exec,
  output logic [XLEN-1:0] rs2_data_exec,
  output logic [XLEN-1:0] imm_exec,
  output logic [4:0]      rd_exec,
  output logic [4:0]      rs1_exec,
  output logic [4:0]      rs2_exec,
  output logic [2:0]      funct3_exec,
  output logic [3:0]      alu_ctrl_exec,
  output logic            alu_src_exec,
  output logic [1:0]      result_src_exec,
  output logic            reg_write_exec,
  output logic            mem_read_exec,
  output logic            mem_write_exec,
  output logic            branch_exec,
  output logic            jump_exec,
  output logic [XLEN-1:0] pc_exec,
  output logic [XLEN-1:0] next_pc_exec,
  output logic            valid_exec,
  output logic            illegal_exec
);

  logic [XLEN-1:0] rs1_data, rs2_data;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  dx_t             dec;
  dx_t             ex_d, ex_q;

  instr_decode_stage_reg_file #(
    .XLEN     (XLEN),
    .NUM_REGS (NUM_REGS)
  ) u_reg_file (
    .clk      (clk),
    .reset    (reset),
    .rs1_addr (instr_decode[19:15]),
    .rs2_addr (instr_decode[24:20]),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .wb_we    (wb_we),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data)
  );

  assign imm_i = {{20{instr_decode[31]}}, instr_decode[31:20]};
  assign imm_s = {{20{instr_decode[31]}}, instr_decode[31:25], instr_decode[11:7]};
  assign imm_b = {{20{instr_decode[31]}}, instr_decode[7], instr_decode[30:25],
                  instr_decode[11:8], 1'b0};
  assign imm_u = {instr_decode[31:12], 12'b0};
  assign imm_j = {{12{instr_decode[31]}}, instr_decode[19:12], instr_decode[20],
                  instr_decode[30:21], 1'b0};

  always_comb begin
    dec          = '0;
    dec.rs1_data = rs1_data;
    dec.rs2_data = rs2_data;
    dec.pc       = pc_decode;
    dec.next_pc  = next_pc_decode;
    dec.rd       = instr_decode[11:7];
    dec.rs1      = instr_decode[19:15];
    dec.rs2      = instr_decode[24:20];
    dec.funct3   = instr_decode[14:12];
    dec.valid    = 1'b1;
    case (instr_decode[6:0])
      OPC_LUI: begin
        dec.imm        = imm_u;
        dec.alu_src    = 1'b1;
        dec.result_src = RES_IMM;
        dec.reg_write  = 1'b1;
      end
      OPC_AUIPC: begin
        dec.imm       = imm_u;
        dec.alu_src   = 1'b1;
        dec.alu_ctrl  = ALU_ADD_PC;
        dec.reg_write = 1'b1;
      end
      OPC_JAL: begin
        dec.imm        = imm_j;
        dec.alu_src    = 1'b1;
        dec.alu_ctrl   = ALU_ADD_PC;
        dec.result_src = RES_NEXT_PC;
        dec.reg_write  = 1'b1;
        dec.jump       = 1'b1;
      end
      OPC_JALR: begin
        dec.imm        = imm_i;
        dec.alu_src    = 1'b1;
        dec.result_src = RES_NEXT_PC;
        dec.reg_write  = 1'b1;
        dec.jump       = 1'b1;
      end
      OPC_BRANCH: begin
        dec.imm      = imm_b;
        dec.alu_ctrl = ALU_SUB;
        dec.branch   = 1'b1;
      end
      OPC_LOAD: begin
        dec.imm        = imm_i;
        dec.alu_src    = 1'b1;
        dec.result_src = RES_MEM;
        dec.reg_write  = 1'b1;
        dec.mem_read   = 1'b1;
      end
      OPC_STORE: begin
        dec.imm       = imm_s;
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
      end
      OPC_OP_IMM: begin
        dec.imm       = imm_i;
        dec.alu_src   = 1'b1;
        dec.alu_ctrl  = alu_op(instr_decode[14:12], instr_decode[30], 1'b0);
        dec.reg_write = 1'b1;
      end
      OPC_OP: begin
        dec.alu_ctrl  = alu_op(instr_decode[14:12], instr_decode[30], 1'b1);
        dec.reg_write = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
    // A bubble from fetch loads all-zero, data fields included.
    if (!valid) dec = '0;
  end

  always_comb begin
    if (flush)      ex_d = '0;
    else if (stall) ex_d = ex_q;
    else            ex_d = dec;
  end

  always_ff @(posedge clk) begin
    if (!reset) ex_q <= '0;
    else        ex_q <= ex_d;
  end

  assign rs1_data_exec   = ex_q.rs1_data;
  assign rs2_data_exec   = ex_q.rs2_data;
  assign imm_exec        = ex_q.imm;
  assign rd_exec         = ex_q.rd;
  assign rs1_exec        = ex_q.rs1;
  assign rs2_exec        = ex_q.rs2;
  assign funct3_exec     = ex_q.funct3;
  assign alu_ctrl_exec   = ex_q.alu_ctrl;
  assign alu_src_exec    = ex_q.alu_src;
  assign result_src_exec = ex_q.result_src;
  assign reg_write_exec  = ex_q.reg_write;
  assign mem_read_exec   = ex_q.mem_read;
  assign mem_write_exec  = ex_q.mem_write;
  assign branch_exec     = ex_q.branch;
  assign jump_exec       = ex_q.jump;
  assign pc_exec         = ex_q.pc;
  assign next_pc_exec    = ex_q.next_pc;
  assign valid_exec      = ex_q.valid;
  assign illegal_exec    = ex_q.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
module tb_instr_decode_stage;
  import instr_decode_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instr_decode = '0, pc_decode = '0, next_pc_decode = '0;
  logic        valid = 1'b0, stall = 1'b0, flush = 1'b0, wb_we = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic [31:0] rs1_data_exec, rs2_data_exec, imm_exec, pc_exec, next_pc_exec;
  logic [4:0]  rd_exec, rs1_exec, rs2_exec;
  logic [2:0]  funct3_exec;
  logic [3:0]  alu_ctrl_exec;
  logic [1:0]  result_src_exec;
  logic        alu_src_exec, reg_write_exec, mem_read_exec, mem_write_exec;
  logic        branch_exec, jump_exec, valid_exec, illegal_exec;

  instr_decode_stage dut (
    .clk(clk), .reset(reset), .instr_decode(instr_decode), .pc_decode(pc_decode),
    .next_pc_decode(next_pc_decode), .valid(valid), .stall(stall), .flush(flush),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .rs1_data_exec(rs1_data_exec), .rs2_data_exec(rs2_data_exec), .imm_exec(imm_exec),
    .rd_exec(rd_exec), .rs1_exec(rs1_exec), .rs2_exec(rs2_exec),
    .funct3_exec(funct3_exec), .alu_ctrl_exec(alu_ctrl_exec), .alu_src_exec(alu_src_exec),
    .result_src_exec(result_src_exec), .reg_write_exec(reg_write_exec),
    .mem_read_exec(mem_read_exec), .mem_write_exec(mem_write_exec),
    .branch_exec(branch_exec), .jump_exec(jump_exec), .pc_exec(pc_exec),
    .next_pc_exec(next_pc_exec), .valid_exec(valid_exec), .illegal_exec(illegal_exec)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rs1_data, rs2_data, imm, pc, next_pc;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [3:0]  alu_ctrl;
    logic        alu_src;
    logic [1:0]  result_src;
    logic        reg_write, mem_read, mem_write, branch, jump, valid, illegal;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur_exp = '0;
  logic [31:0] rf [32];
  int          checks = 0, errors = 0;
  bit          armed = 0;

  // Reference decode written from the ISA tables: immediates built by
  // arithmetic on the field values rather than by bit concatenation.
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                      input logic [31:0] npc, input logic v,
                                      input logic [31:0] r1, input logic [31:0] r2);
    exp_t e = '0;
    logic signed [31:0] si;
    int b;
    logic [3:0] f3_alu [8];
    f3_alu = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    if (!v) return e;
    si = ins;
    e.valid = 1; e.rs1_data = r1; e.rs2_data = r2; e.pc = pc; e.next_pc = npc;
    e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.funct3 = ins[14:12];
    case (ins[6:0])
      7'h37: begin e.imm = ins & 32'hFFFF_F000; e.alu_src = 1; e.result_src = 2'b11;
                   e.reg_write = 1; end
      7'h17: begin e.imm = ins & 32'hFFFF_F000; e.alu_src = 1; e.alu_ctrl = ALU_ADD_PC;
                   e.reg_write = 1; end
      7'h6F: begin
        b = (ins[31] ? -(1 << 20) : 0) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048
            + int'(ins[30:21]) * 2;
        e.imm = b; e.alu_src = 1; e.alu_ctrl = ALU_ADD_PC; e.result_src = 2'b10;
        e.reg_write = 1; e.jump = 1;
      end
      7'h67: begin e.imm = si >>> 20; e.alu_src = 1; e.result_src = 2'b10;
                   e.reg_write = 1; e.jump = 1; end
      7'h63: begin
        b = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32
            + int'(ins[11:8]) * 2;
        e.imm = b; e.alu_ctrl = ALU_SUB; e.branch = 1;
      end
      7'h03: begin e.imm = si >>> 20; e.alu_src = 1; e.result_src = 2'b01;
                   e.reg_write = 1; e.mem_read = 1; end
      7'h23: begin e.imm = ((si >>> 25) * 32) + int'(ins[11:7]); e.alu_src = 1;
                   e.mem_write = 1; end
      7'h13: begin
        e.imm = si >>> 20; e.alu_src = 1; e.reg_write = 1;
        e.alu_ctrl = f3_alu[ins[14:12]];
        if (ins[14:12] == 3'd5 && ins[30]) e.alu_ctrl = ALU_SRA;
      end
      7'h33: begin
        e.reg_write = 1; e.alu_ctrl = f3_alu[ins[14:12]];
        if (ins[14:12] == 3'd0 && ins[30]) e.alu_ctrl = ALU_SUB;
        if (ins[14:12] == 3'd5 && ins[30]) e.alu_ctrl = ALU_SRA;
      end
      default: e.illegal = 1;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] a);
    if (a == 0) return '0;
`ifdef WB_BYPASS_EN
    if (wb_we && wb_rd == a) return wb_data;
`endif
    return rf[a];
  endfunction

  // Drive one cycle of inputs and queue the response expected after the next edge.
  task automatic step(input logic [31:0] ins, input logic v, input logic st,
                      input logic fl, input logic rst_n, input logic we,
                      input logic [4:0] rd, input logic [31:0] data);
    logic [31:0] pc;
    @(negedge clk);
    pc = $urandom() & 32'hFFFF_FFFC;
    instr_decode = ins; valid = v; stall = st; flush = fl; reset = rst_n;
    wb_we = we; wb_rd = rd; wb_data = data;
    pc_decode = pc; next_pc_decode = pc + 32'd4;
    if (!rst_n || fl) cur_exp = '0;
    else if (!st) cur_exp = ref_decode(ins, pc, pc + 32'd4, v, ref_read(ins[19:15]),
                                       ref_read(ins[24:20]));
    exp_q.push_back(cur_exp);
    armed = 1;
    if (!rst_n) foreach (rf[i]) rf[i] = '0;
    else if (we && rd != 0) rf[rd] = data;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("valid_illegal", {62'd0, valid_exec, illegal_exec}, {62'd0, e.valid, e.illegal});
        check("ctrl", {51'd0, alu_ctrl_exec, alu_src_exec, result_src_exec, reg_write_exec,
                       mem_read_exec, mem_write_exec, branch_exec, jump_exec},
                      {51'd0, e.alu_ctrl, e.alu_src, e.result_src, e.reg_write,
                       e.mem_read, e.mem_write, e.branch, e.jump});
        check("imm", {32'd0, imm_exec}, {32'd0, e.imm});
        check("operands", {rs1_data_exec, rs2_data_exec}, {e.rs1_data, e.rs2_data});
        check("indices", {46'd0, rd_exec, rs1_exec, rs2_exec, funct3_exec},
                         {46'd0, e.rd, e.rs1, e.rs2, e.funct3});
        check("pcs", {pc_exec, next_pc_exec}, {e.pc, e.next_pc});
      end else if (armed) begin
        check("scoreboard_empty", 64'd0, 64'd1);
      end
    end
  end

  initial begin : stimulus
    logic [6:0]  ops [10];
    logic [31:0] r, ins;
    int          waited;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h7F};
    foreach (rf[i]) rf[i] = '0;
    step('0, 0, 0, 0, 0, 0, 0, '0);                          // reset
    step('0, 0, 0, 0, 0, 0, 0, '0);
    step(32'h0050_0093, 1, 0, 0, 1, 0, 0, '0);               // addi x1,x0,5
    step(32'hFE00_0EE3, 1, 0, 0, 1, 0, 0, '0);               // beq x0,x0,-4
    step(32'h0031_8233, 1, 0, 0, 1, 1, 5'd3, 32'hDEAD_BEEF); // add x4,x3,x3 + wb x3
    step(32'h0031_8233, 1, 1, 0, 1, 0, 0, '0);               // stall holds
    step(32'h0031_8233, 1, 0, 0, 1, 0, 0, '0);               // reread x3
    step(32'h0000_0093, 1, 0, 0, 1, 1, 5'd0, 32'h1234);      // wb x0 ignored
    step(32'h0000_02B3, 1, 0, 0, 1, 0, 0, '0);               // add x5,x0,x0
    step(32'h0050_0093, 1, 1, 1, 1, 0, 0, '0);               // stall+flush -> bubble
    step(32'h0050_0093, 1, 0, 0, 1, 1, 5'd1, 32'h55);        // load, write x1
    step(32'hFE00_0EE3, 1, 1, 0, 1, 0, 0, '0);               // stall alone holds
    step(32'h0010_8133, 1, 0, 0, 0, 0, 0, '0);               // mid-stream reset
    step(32'h0010_8133, 1, 0, 0, 1, 0, 0, '0);               // add x2,x1,x1 -> 0
    step(32'h0000_007F, 1, 0, 0, 1, 0, 0, '0);               // illegal opcode
    step(32'h4020_D213, 1, 0, 0, 1, 0, 0, '0);               // srai x4,x1,2
    for (int n = 0; n < 400; n++) begin
      r = $urandom();
      ins = {r[31:7], ops[$urandom_range(0, 9)]};
      step(ins, ($urandom_range(0, 99) < 85), ($urandom_range(0, 99) < 20),
           ($urandom_range(0, 99) < 10), ($urandom_range(0, 99) >= 3),
           ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 31)), $urandom());
    end
    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (exp_q.size() > 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
